// File: rtl/am2940_pkg.sv
// Shared definitions for the Am2940-style DMA transfer sequencer.
// Opcodes, FSM states, word-count modes and readback select codes.
package am2940_pkg;

    localparam logic [2:0] OP_WRCR   = 3'b000;
    localparam logic [2:0] OP_RDCR   = 3'b001;
    localparam logic [2:0] OP_RDWC   = 3'b010;
    localparam logic [2:0] OP_RDAC   = 3'b011;
    localparam logic [2:0] OP_REINIT = 3'b100;
    localparam logic [2:0] OP_LDADR  = 3'b101;
    localparam logic [2:0] OP_LDWC   = 3'b110;
    localparam logic [2:0] OP_ENCNT  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_DONE   = 2'b10,
        ST_RELOAD = 2'b11
    } state_t;

    localparam logic [1:0] WC_DOWN = 2'b00;
    localparam logic [1:0] WC_UP   = 2'b01;

    localparam logic [1:0] RD_NONE = 2'b00;
    localparam logic [1:0] RD_CR   = 2'b01;
    localparam logic [1:0] RD_WC   = 2'b10;
    localparam logic [1:0] RD_AC   = 2'b11;

    typedef struct packed {
        logic wrcr;
        logic rdcr;
        logic rdwc;
        logic rdac;
        logic reinit;
        logic ldadr;
        logic ldwc;
        logic encnt;
    } cmd_t;

endpackage

// File: rtl/am2940_instr_decode.sv
// Opcode decoder: 3-bit instruction to one-hot command strobes.
// All strobes are low unless the instruction strobe is high.
module am2940_instr_decode
    import am2940_pkg::*;
(
    input  logic [2:0] instr_i,
    input  logic       valid_i,
    output cmd_t       cmd_o
);

    // One-hot decode, gated by the instruction strobe
    always_comb begin
        cmd_o = '0;
        if (valid_i) begin
            unique case (instr_i)
                OP_WRCR:   cmd_o.wrcr   = 1'b1;
                OP_RDCR:   cmd_o.rdcr   = 1'b1;
                OP_RDWC:   cmd_o.rdwc   = 1'b1;
                OP_RDAC:   cmd_o.rdac   = 1'b1;
                OP_REINIT: cmd_o.reinit = 1'b1;
                OP_LDADR:  cmd_o.ldadr  = 1'b1;
                OP_LDWC:   cmd_o.ldwc   = 1'b1;
                OP_ENCNT:  cmd_o.encnt  = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/am2940_xfer_sequencer.sv
// Command side of an Am2940-style DMA generator: control register,
// shadows and RUN/DONE FSM. Option: AUTO_REINIT_EN adds a RELOAD state.
module am2940_xfer_sequencer
    import am2940_pkg::*;
#(
    parameter int         DATA_W   = 16,
    parameter logic [2:0] CR_RESET = 3'b000
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic [2:0]        instr,
    input  logic              instr_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              xfer_stb,
    input  logic [DATA_W-1:0] wc_value,
    output logic              ac_load,
    output logic              ac_enable,
    output logic              ac_up,
    output logic [DATA_W-1:0] ac_load_data,
    output logic              wc_load,
    output logic              wc_enable,
    output logic              wc_up,
    output logic [DATA_W-1:0] wc_load_data,
    output logic [2:0]        cr_out,
    output logic [1:0]        rd_sel,
    output logic              running,
    output logic              done
);

    state_t            state_q, state_d;
    logic [2:0]        cr_q, cr_d;
    logic [DATA_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] wc_q, wc_d;
    logic [1:0]        rd_q, rd_d;
    logic              done_q, done_d;

    logic ac_ld_c, wc_ld_c, ac_en_c, wc_en_c;
    logic term;
    cmd_t cmd;

    am2940_instr_decode u_dec (
        .instr_i (instr),
        .valid_i (instr_valid),
        .cmd_o   (cmd)
    );

    assign term = ((cr_q[1:0] == WC_DOWN) && (wc_value == DATA_W'(1)))
               || ((cr_q[1:0] == WC_UP) && (&wc_value));

    // Next-state, shadow updates and combinational chain strobes
    always_comb begin
        state_d      = state_q;
        cr_d         = cr_q;
        adr_d        = adr_q;
        wc_d         = wc_q;
        rd_d         = rd_q;
        done_d       = done_q;
        ac_ld_c      = 1'b0;
        wc_ld_c      = 1'b0;
        ac_en_c      = 1'b0;
        wc_en_c      = 1'b0;
        ac_load_data = adr_q;
        wc_load_data = wc_q;
`ifdef AUTO_REINIT_EN
        if (state_q == ST_RELOAD) done_d = 1'b0;
`endif
        if (instr_valid) begin
            rd_d = RD_NONE;
            if (state_q != ST_RUN) state_d = ST_IDLE;
            unique case (1'b1)
                cmd.wrcr: cr_d = data_in[2:0];
                cmd.rdcr: rd_d = RD_CR;
                cmd.rdwc: rd_d = RD_WC;
                cmd.rdac: rd_d = RD_AC;
                cmd.reinit: begin
                    ac_ld_c = 1'b1;
                    wc_ld_c = 1'b1;
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                end
                cmd.ldadr: begin
                    adr_d        = data_in;
                    ac_ld_c      = 1'b1;
                    ac_load_data = data_in;
                end
                cmd.ldwc: begin
                    wc_d         = data_in;
                    wc_ld_c      = 1'b1;
                    wc_load_data = data_in;
                end
                cmd.encnt: begin
                    state_d = ST_RUN;
                    done_d  = 1'b0;
                end
                default: ;
            endcase
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (xfer_stb) begin
                        ac_en_c = 1'b1;
                        wc_en_c = 1'b1;
                        if (term) begin
                            done_d = 1'b1;
`ifdef AUTO_REINIT_EN
                            state_d = ST_RELOAD;
`else
                            state_d = ST_DONE;
`endif
                        end
                    end
                end
`ifdef AUTO_REINIT_EN
                ST_RELOAD: begin
                    ac_ld_c = 1'b1;
                    wc_ld_c = 1'b1;
                    state_d = ST_RUN;
                end
`endif
                default: ;
            endcase
        end
    end

    // State and register file update
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q <= ST_IDLE;
            cr_q    <= CR_RESET;
            adr_q   <= '0;
            wc_q    <= '0;
            rd_q    <= RD_NONE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cr_q    <= cr_d;
            adr_q   <= adr_d;
            wc_q    <= wc_d;
            rd_q    <= rd_d;
            done_q  <= done_d;
        end
    end

    assign ac_load   = res_n & ac_ld_c;
    assign wc_load   = res_n & wc_ld_c;
    assign ac_enable = res_n & ac_en_c;
    assign wc_enable = res_n & wc_en_c;
    assign ac_up     = ~cr_q[2];
    assign wc_up     = (cr_q[1:0] == WC_UP);
    assign cr_out    = cr_q;
    assign rd_sel    = rd_q;
    assign running   = (state_q == ST_RUN);
    assign done      = done_q;

endmodule

// File: tb/tb_am2940_xfer_sequencer.sv
// Directed bench for am2940_xfer_sequencer.
// Inputs change after the falling edge; outputs are sampled 1ns later.
module tb_am2940_xfer_sequencer;

    logic        clk = 1'b0;
    logic        res_n;
    logic [2:0]  instr;
    logic        instr_valid;
    logic [15:0] data_in;
    logic        xfer_stb;
    logic [15:0] wc_value;
    logic        ac_load, ac_enable, ac_up;
    logic [15:0] ac_load_data;
    logic        wc_load, wc_enable, wc_up;
    logic [15:0] wc_load_data;
    logic [2:0]  cr_out;
    logic [1:0]  rd_sel;
    logic        running, done;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    am2940_xfer_sequencer #(.DATA_W(16), .CR_RESET(3'b000)) dut (
        .clk          (clk),
        .res_n        (res_n),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .data_in      (data_in),
        .xfer_stb     (xfer_stb),
        .wc_value     (wc_value),
        .ac_load      (ac_load),
        .ac_enable    (ac_enable),
        .ac_up        (ac_up),
        .ac_load_data (ac_load_data),
        .wc_load      (wc_load),
        .wc_enable    (wc_enable),
        .wc_up        (wc_up),
        .wc_load_data (wc_load_data),
        .cr_out       (cr_out),
        .rd_sel       (rd_sel),
        .running      (running),
        .done         (done)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [2:0] op,
                       input logic [15:0] d, input logic x,
                       input logic [15:0] wc);
        @(negedge clk);
        instr_valid = v;
        instr       = op;
        data_in     = d;
        xfer_stb    = x;
        wc_value    = wc;
        #1;
    endtask

    initial begin
        res_n = 1'b0; instr = 3'd0; instr_valid = 1'b0;
        data_in = '0; xfer_stb = 1'b1; wc_value = 16'd1;
        #1;
        chk("rst_run", running, 0);
        chk("rst_done", done, 0);
        chk("rst_cr", cr_out, 0);
        chk("rst_rd", rd_sel, 0);
        chk("rst_aen", ac_enable, 0);
        @(negedge clk);
        @(negedge clk);
        res_n = 1'b1;

        // 1: down count of 3
        drv(1, 3'b101, 16'h1000, 0, 0);
        chk("t1_acld", ac_load, 1);
        chk("t1_acdat", ac_load_data, 16'h1000);
        drv(1, 3'b110, 16'd3, 0, 0);
        chk("t1_wcld", wc_load, 1);
        chk("t1_wcdat", wc_load_data, 16'd3);
        drv(1, 3'b000, 16'h0000, 0, 0);
        drv(1, 3'b111, 16'h0000, 0, 0);
        chk("t1_idle", running, 0);
        drv(0, 3'b000, 0, 1, 16'd3);
        chk("t1_run", running, 1);
        chk("t1_aen0", ac_enable, 1);
        chk("t1_wen0", wc_enable, 1);
        chk("t1_acup", ac_up, 1);
        chk("t1_wcup", wc_up, 0);
        drv(0, 3'b000, 0, 1, 16'd2);
        chk("t1_aen1", ac_enable, 1);
        chk("t1_done1", done, 0);
        drv(0, 3'b000, 0, 1, 16'd1);
        chk("t1_wen2", wc_enable, 1);
        chk("t1_done2", done, 0);
        drv(0, 3'b000, 0, 0, 16'd0);
        chk("t1_done", done, 1);
        chk("t1_stop", running, 0);
`ifdef AUTO_REINIT_EN
        // 6: automatic reload from shadows
        chk("t6_acld", ac_load, 1);
        chk("t6_wcld", wc_load, 1);
        chk("t6_acdat", ac_load_data, 16'h1000);
        chk("t6_wcdat", wc_load_data, 16'd3);
        drv(0, 3'b000, 0, 1, 16'd3);
        chk("t6_run", running, 1);
        chk("t6_pulse", done, 0);
        chk("t6_aen", ac_enable, 1);
`else
        drv(0, 3'b000, 0, 1, 16'd1);
        chk("t1_hold", done, 1);
        chk("t1_ign", ac_enable, 0);
`endif

        // 4: REINIT reloads both chains from the shadows
        drv(1, 3'b100, 16'h0000, 0, 0);
        chk("t4_acld", ac_load, 1);
        chk("t4_wcld", wc_load, 1);
        chk("t4_acdat", ac_load_data, 16'h1000);
        chk("t4_wcdat", wc_load_data, 16'd3);
        drv(0, 3'b000, 0, 0, 0);
        chk("t4_done", done, 0);
        chk("t4_idle", running, 0);

        // 2: up count from 0xFFFE
        drv(1, 3'b110, 16'hFFFE, 0, 0);
        drv(1, 3'b000, 16'h0001, 0, 0);
        drv(1, 3'b111, 16'h0000, 0, 0);
        chk("t2_cr", cr_out, 3'b001);
        chk("t2_up0", wc_up, 1);
        drv(0, 3'b000, 0, 1, 16'hFFFE);
        chk("t2_en0", wc_enable, 1);
        chk("t2_up1", wc_up, 1);
        drv(0, 3'b000, 0, 1, 16'hFFFF);
        chk("t2_en1", wc_enable, 1);
        chk("t2_nd", done, 0);
        drv(0, 3'b000, 0, 0, 16'h0000);
        chk("t2_done", done, 1);
        chk("t2_up2", wc_up, 1);

        // 3: instruction wins over a same-cycle strobe
        drv(1, 3'b000, 16'h0004, 0, 0);
        drv(1, 3'b110, 16'd5, 0, 0);
        drv(1, 3'b111, 16'h0000, 0, 0);
        chk("t3_acup", ac_up, 0);
        drv(1, 3'b101, 16'h0055, 1, 16'd5);
        chk("t3_acld", ac_load, 1);
        chk("t3_acdat", ac_load_data, 16'h0055);
        chk("t3_aen", ac_enable, 0);
        chk("t3_wen", wc_enable, 0);
        drv(1, 3'b011, 16'h0000, 0, 16'd5);
        chk("t3_run", running, 1);
        drv(0, 3'b000, 0, 1, 16'd5);
        chk("t3_rd", rd_sel, 2'b11);
        chk("t3_aen2", ac_enable, 1);

        // 5: asynchronous reset mid-transfer
        #2;
        res_n = 1'b0;
        #1;
        chk("t5_aen", ac_enable, 0);
        chk("t5_wen", wc_enable, 0);
        chk("t5_run", running, 0);
        @(negedge clk);
        res_n = 1'b1;
        drv(0, 3'b000, 0, 1, 16'd5);
        chk("t5_cr", cr_out, 3'b000);
        chk("t5_idle", running, 0);
        chk("t5_rd", rd_sel, 0);
        chk("t5_ign", wc_enable, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
